// File: rtl/gray_rd_arb.sv
// gray_rd_arb: burst round-robin arbiter sharing the single-port gray-image
// read memory among NREQ LBP window-fetch engines. Grants are registered and
// one-hot; the 1-cycle read data comes back with a per-requester rvalid strobe.
// Optional build macro GRAY_ARB_FIXED_PRIO_EN: when defined, IDLE arbitration
// is fixed priority (lowest index wins) instead of round-robin.
module gray_rd_arb #(
  parameter int NREQ      = 2,
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int MAX_BURST = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 mem_rd,
  output logic [AW-1:0]        mem_addr,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [IW-1:0]   last_q, last_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [BW-1:0]   beat_inc;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [IW-1:0]   owner;
  logic [IW-1:0]   winner;
  logic            others;

  // Unpack the per-requester address slices.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
    assign addr_arr[gi] = addr[gi*AW +: AW];
  end

  // Index of the current owner (grant is one-hot or zero).
  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) owner = IW'(i);
    end
  end

`ifdef GRAY_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) winner = IW'(i);
    end
  end
`else
  // Round-robin: first requester found scanning last+1, last+2, ... mod NREQ.
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_q) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`endif

  assign others   = |(req & ~gnt_q);
  assign beat_inc = beat_q + 1'b1;
  assign mem_rd   = |(gnt_q & req);
  assign mem_addr = (|gnt_q) ? addr_arr[owner] : '0;
  assign rdata    = mem_rdata;
  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign busy     = (state_q == OWN);

  // Next-state logic: grant in IDLE, count beats and release/renew in OWN.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    beat_d   = beat_q;
    rvalid_d = gnt_q & req;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d[winner] = 1'b1;
          last_d        = winner;
          beat_d        = '0;
          state_d       = OWN;
        end
      end
      default: begin
        if (!req[owner]) begin
          // Owner let go: no beat this cycle, back to arbitration.
          state_d = IDLE;
          gnt_d   = '0;
          beat_d  = '0;
        end else if (beat_inc == BEAT_MAX) begin
          // Burst complete: hand off if anyone else waits, else renew.
          beat_d = '0;
          if (others) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
          beat_d = beat_inc;
        end
      end
    endcase
  end

  // State registers with asynchronous reset; in-flight reads are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      last_q   <= IW'(NREQ - 1);
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_gray_rd_arb.sv
// tb_gray_rd_arb: directed and random request patterns against a cycle-level
// behavioural model of the burst arbiter and a synthetic gray memory.
module tb_gray_rd_arb;

  localparam int NREQ = 2;
  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int MAXB = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rvalid;
  logic [DW-1:0]     rdata;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_rdata = '0;
  logic              busy;

  gray_rd_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synthetic image content as a function of the pixel address.
  function automatic logic [7:0] pix(input logic [13:0] a);
    logic [13:0] t;
    t = a ^ 14'h1a5;
    return t[7:0] ^ {2'b10, t[13:8]};
  endfunction

  // Single-port memory with one-cycle read latency.
  always @(posedge clk) if (mem_rd) mem_rdata <= pix(mem_addr);

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner (-1 when idle), beats in current burst, last winner,
  // requester whose read data returns this cycle and that data.
  int         m_own = -1;
  int         m_beats = 0;
  int         m_last = NREQ - 1;
  int         m_rv = -1;
  logic [7:0] m_rdata = '0;

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef GRAY_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_beats = 0; m_last = NREQ - 1; m_rv = -1;
  endtask

  // Compare all outputs for the current cycle, then advance the model.
  task automatic check_and_advance(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a);
    logic [13:0] own_addr;
    logic [NREQ-1:0] eg, erv, others;
    bit iss;
    int w;
    own_addr = (m_own >= 0) ? 14'(a >> (m_own * AW)) : 14'd0;
    eg  = (m_own >= 0) ? NREQ'(1 << m_own) : '0;
    erv = (m_rv >= 0) ? NREQ'(1 << m_rv) : '0;
    iss = (m_own >= 0) && r[m_own];
    check_val("gnt", 32'(gnt), 32'(eg));
    check_val("busy", 32'(busy), 32'(m_own >= 0));
    check_val("mem_rd", 32'(mem_rd), 32'(iss));
    check_val("mem_addr", 32'(mem_addr), 32'(own_addr));
    check_val("rvalid", 32'(rvalid), 32'(erv));
    if (m_rv >= 0) check_val("rdata", 32'(rdata), 32'(m_rdata));
    if (m_own < 0) begin
      m_rv = -1;
      if (r != 0) begin
        w = pick(r, m_last);
        m_own = w; m_last = w; m_beats = 0;
        $display("cycle %0d: grant to requester %0d (req=%b)", cyc + 1, w, r);
      end
    end else begin
      m_rv = iss ? m_own : -1;
      m_rdata = pix(own_addr);
      if (!iss) m_own = -1;
      else begin
        m_beats++;
        if (m_beats == MAXB) begin
          m_beats = 0;
          others = r & ~eg;
          if (others != 0) m_own = -1;
        end
      end
    end
    cyc++;
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a);
    @(negedge clk);
    req = r; addr = a;
    #1;
    check_and_advance(r, a);
  endtask

  // Assert reset between edges, check outputs clear at once, release a cycle later.
  task automatic do_reset(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a);
    @(negedge clk);
    req = r; addr = a; reset = 1'b1;
    #1;
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_rvalid", 32'(rvalid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_and_advance(r, a);
  endtask

  function automatic logic [NREQ*AW-1:0] rnd_addr();
    return (NREQ*AW)'({$urandom, $urandom});
  endfunction

  int seq[9] = '{0, 1, 2, 128, 130, 256, 257, 258, 129};
  logic [NREQ-1:0] hold;
  bit hit;

  initial begin
    #1 reset = 1'b1;
    do_reset('0, '0);
    step('0, '0);

    // Single requester fetching one 3x3 window.
    for (int i = 0; i < 9; i++) step(2'b01, (NREQ*AW)'(seq[i]));
    for (int i = 0; i < 3; i++) step('0, '0);

    // Both requesters contending with fixed addresses.
    for (int i = 0; i < 42; i++) step(2'b11, {14'h2000, 14'h0000});
    for (int i = 0; i < 2; i++) step('0, '0);

    // Lone requester 1 streaming across several burst boundaries.
    for (int i = 0; i < 31; i++) step(2'b10, rnd_addr());
    for (int i = 0; i < 2; i++) step('0, '0);

    // Early release by requester 0 while requester 1 waits.
    for (int i = 0; i < 5; i++) step(2'b11, rnd_addr());
    for (int i = 0; i < 5; i++) step(2'b10, rnd_addr());
    for (int i = 0; i < 2; i++) step('0, '0);

    // Random holding/releasing requesters.
    hold = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (hold[j]) begin if ($urandom_range(11) == 0) hold[j] = 1'b0; end
        else if ($urandom_range(3) == 0) hold[j] = 1'b1;
      end
      step(hold, rnd_addr());
    end
    for (int i = 0; i < 2; i++) step('0, '0);

    // Reset in the middle of requester 1's burst, then both request.
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step(2'b10, rnd_addr());
      if (m_own == 1 && m_beats == 4) hit = 1;
    end
    check_val("reach_beat5", 32'(hit), 32'd1);
    do_reset(2'b11, rnd_addr());
    for (int i = 0; i < 25; i++) step(2'b11, rnd_addr());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
